// File: rtl/mcycle_ctrl_fsm.sv
// mcycle_ctrl_fsm: main control FSM of the multi-cycle ARM datapath with a
// memory ready/wait handshake, an optional iterative-multiply path and a sticky fault state.
`default_nettype none

module mcycle_ctrl_fsm #(
  parameter int MUL_EN      = 1,
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MulOp,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       mul_start,
  output logic       fault,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_MULEX    = 4'd10;
  localparam logic [3:0] S_MULWB    = 4'd11;
  localparam logic [3:0] S_FAULT    = 4'd12;

  // A zero timeout still needs a one-bit counter so the declaration stays legal.
  localparam int               WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [7:0]        MUL_LOAD  = 8'(MUL_CYCLES - 1);
  localparam logic              MUL_ON    = (MUL_EN != 0);
  localparam logic              TMO_ON    = (MEM_TIMEOUT != 0);

  logic [3:0]        state_q,    state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]        mul_cnt_q,  mul_cnt_d;
  logic              fault_q,    fault_d;
  logic              timeout_hit;
  logic              unused_funct;

  assign unused_funct = ^Funct[4:1];
  assign timeout_hit  = TMO_ON && (wait_cnt_q == TIMEOUT_V) && !mem_ready;

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (Op)
          2'b00: begin
            if (MUL_ON && MulOp && !Funct[5]) begin
              state_d   = S_MULEX;
              mul_cnt_d = MUL_LOAD;
            end else if (Funct[5]) begin
              state_d = S_EXECUTEI;
            end else begin
              state_d = S_EXECUTER;
            end
          end
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FAULT;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)        state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_MEMWR: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_MULEX: begin
        if (mul_cnt_q == 8'd0) state_d   = S_MULWB;
        else                   mul_cnt_d = mul_cnt_q - 8'd1;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_MULWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
  end

  // Counting only while the same memory state persists clears it on entry and on completion.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_req && !mem_ready && (state_d == state_q))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign fault_d = fault_q | (state_d == S_FAULT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      mul_cnt_q  <= 8'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mul_cnt_q  <= mul_cnt_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        NextPC    = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
      end
      S_MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b01;
      end
      S_ALUWB:    RegW = 1'b1;
      // The counter only holds its load value during the first MULEX cycle.
      S_MULEX:    mul_start = (mul_cnt_q == MUL_LOAD);
      S_MULWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b11;
      end
      S_BRANCH: begin
        Branch    = 1'b1;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
      end
      default: ;
    endcase
  end

  assign fault   = fault_q;
  assign state_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mcycle_ctrl_fsm.sv
// tb_mcycle_ctrl_fsm: directed checks of mcycle_ctrl_fsm; one instance with the
// multiplier enabled and one with it disabled, both with a 4-cycle memory timeout.
`default_nettype none

module tb_mcycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'h00;
  logic       MulOp = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp, mul_start, fault;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] state_o;
  logic       mem_req2, IRWrite2, AdrSrc2, ALUSrcA2, NextPC2, RegW2, MemW2, Branch2, ALUOp2, mul_start2, fault2;
  logic [1:0] ALUSrcB2, ResultSrc2;
  logic [3:0] state_o2;
  logic [14:0] ctl, ctl2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ctl  = {mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, mul_start, fault};
  assign ctl2 = {mem_req2, IRWrite2, AdrSrc2, ALUSrcA2, ALUSrcB2, ResultSrc2, NextPC2, RegW2, MemW2, Branch2, ALUOp2, mul_start2, fault2};

  mcycle_ctrl_fsm #(.MUL_EN(1), .MUL_CYCLES(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .ALUOp(ALUOp), .mul_start(mul_start), .fault(fault), .state_o(state_o)
  );

  mcycle_ctrl_fsm #(.MUL_EN(0), .MUL_CYCLES(4), .MEM_TIMEOUT(4)) dut_nomul (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .mem_ready(mem_ready),
    .mem_req(mem_req2), .IRWrite(IRWrite2), .AdrSrc(AdrSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ResultSrc(ResultSrc2), .NextPC(NextPC2), .RegW(RegW2), .MemW(MemW2), .Branch(Branch2),
    .ALUOp(ALUOp2), .mul_start(mul_start2), .fault(fault2), .state_o(state_o2)
  );

  // Control bundle per state, hand-written from the output table:
  // {mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB[2], ResultSrc[2], NextPC, RegW, MemW, Branch, ALUOp, mul_start, fault}
  function automatic logic [14:0] exp_ctl(input int s, input logic r, input logic first);
    case (s)
      0:  return {1'b1, r, 1'b0, 1'b1, 2'b10, 2'b10, r, 6'b0};
      1:  return {3'b000, 1'b1, 2'b10, 2'b10, 7'b0};
      2:  return {4'b0, 2'b01, 2'b00, 7'b0};
      3:  return {1'b1, 1'b0, 1'b1, 1'b0, 4'b0, 7'b0};
      4:  return {4'b0, 2'b00, 2'b01, 1'b0, 1'b1, 5'b0};
      5:  return {1'b1, 1'b0, 1'b1, 1'b0, 4'b0, 2'b00, 1'b1, 4'b0};
      6:  return {4'b0, 4'b0, 4'b0, 1'b1, 2'b00};
      7:  return {4'b0, 2'b01, 2'b00, 4'b0, 1'b1, 2'b00};
      8:  return {4'b0, 4'b0, 1'b0, 1'b1, 5'b0};
      9:  return {4'b0, 2'b01, 2'b10, 3'b000, 1'b1, 3'b000};
      10: return {13'b0, first, 1'b0};
      11: return {4'b0, 2'b00, 2'b11, 1'b0, 1'b1, 5'b0};
      12: return {14'b0, 1'b1};
      default: return 15'h7fff;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    total++;
    if ({state_o, ctl} !== {4'd0, exp_ctl(0, 1'b1, 1'b0)}) begin
      bad++; $display("FAIL reset_rdy1: got state=%0d ctl=%b want state=0 ctl=%b", state_o, ctl, exp_ctl(0, 1'b1, 1'b0));
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if ({state_o, ctl} !== {4'd0, exp_ctl(0, 1'b0, 1'b0)}) begin
      bad++; $display("FAIL reset_rdy0: got state=%0d ctl=%b want state=0 ctl=%b", state_o, ctl, exp_ctl(0, 1'b0, 1'b0));
    end
    total++;
    if (dut.wait_cnt_q !== '0 || dut.mul_cnt_q !== 8'd0 || state_o2 !== 4'd0) begin
      bad++; $display("FAIL reset_counters: got wait=%0d mul=%0d state2=%0d want 0 0 0", dut.wait_cnt_q, dut.mul_cnt_q, state_o2);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    int st[5] = '{0, 1, 6, 8, 0};
    Op = 2'b00; Funct = 6'h08; MulOp = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st[i]), exp_ctl(st[i], 1'b1, 1'b0)}) begin
        bad++; $display("FAIL add[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st[i], exp_ctl(st[i], 1'b1, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ldr_wait();
    int st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    bit rd[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    Op = 2'b01; Funct = 6'h01; MulOp = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st[i]), exp_ctl(st[i], rd[i], 1'b0)}) begin
        bad++; $display("FAIL ldr[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st[i], exp_ctl(st[i], rd[i], 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_str_timeout();
    int st[11] = '{0, 1, 2, 5, 5, 5, 5, 5, 12, 12, 12};
    bit rd[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    Op = 2'b01; Funct = 6'h00; MulOp = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      mem_ready = rd[i];
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st[i]), exp_ctl(st[i], rd[i], 1'b0)}) begin
        bad++; $display("FAIL str_tmo[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st[i], exp_ctl(st[i], rd[i], 1'b0));
      end
      @(negedge clk);
    end
    do_reset();
    #1;
    total++;
    if (state_o !== 4'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL str_tmo_clear: got state=%0d fault=%0b want state=0 fault=0", state_o, fault);
    end
  endtask

  task automatic test_mul();
    int st[8] = '{0, 1, 10, 10, 10, 10, 11, 0};
    logic f;
    Op = 2'b00; Funct = 6'h00; MulOp = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b1;
      f = (st[i] == 10) && (st[i-1] != 10);
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st[i]), exp_ctl(st[i], 1'b1, f)}) begin
        bad++; $display("FAIL mul[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st[i], exp_ctl(st[i], 1'b1, f));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul_disabled();
    int st[5] = '{0, 1, 6, 8, 0};
    Op = 2'b00; Funct = 6'h00; MulOp = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if ({state_o2, ctl2} !== {4'(st[i]), exp_ctl(st[i], 1'b1, 1'b0)}) begin
        bad++; $display("FAIL mul_off[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o2, ctl2, st[i], exp_ctl(st[i], 1'b1, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_op();
    int st[5] = '{0, 1, 12, 12, 12};
    Op = 2'b11; Funct = 6'h00; MulOp = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st[i]), exp_ctl(st[i], 1'b1, 1'b0)}) begin
        bad++; $display("FAIL illegal[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st[i], exp_ctl(st[i], 1'b1, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_timeout_edge();
    int st_ok[6]  = '{0, 0, 0, 0, 0, 1};
    bit rd_ok[6]  = '{0, 0, 0, 0, 1, 0};
    int st_bad[7] = '{0, 0, 0, 0, 0, 12, 12};
    Op = 2'b00; Funct = 6'h08; MulOp = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_ready = rd_ok[i];
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st_ok[i]), exp_ctl(st_ok[i], rd_ok[i], 1'b0)}) begin
        bad++; $display("FAIL fetch_edge[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st_ok[i], exp_ctl(st_ok[i], rd_ok[i], 1'b0));
      end
      @(negedge clk);
    end
    do_reset();
    for (int i = 0; i < 7; i++) begin
      mem_ready = 1'b0;
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st_bad[i]), exp_ctl(st_bad[i], 1'b0, 1'b0)}) begin
        bad++; $display("FAIL fetch_tmo[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st_bad[i], exp_ctl(st_bad[i], 1'b0, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_op();
    int st_m[4] = '{0, 1, 10, 10};
    int st_s[5] = '{0, 1, 2, 5, 5};
    bit rd_s[5] = '{1, 1, 1, 0, 0};
    // Multiply interrupted in its second MULEX cycle.
    Op = 2'b00; Funct = 6'h00; MulOp = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if (state_o !== 4'(st_m[i])) begin
        bad++; $display("FAIL rst_mul_seq[%0d]: got state=%0d want %0d", i, state_o, st_m[i]);
      end
      if (i < 3) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    total++;
    if (state_o !== 4'd0 || dut.mul_cnt_q !== 8'd0 || dut.wait_cnt_q !== '0) begin
      bad++; $display("FAIL rst_mul_now: got state=%0d mul=%0d wait=%0d want 0 0 0", state_o, dut.mul_cnt_q, dut.wait_cnt_q);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (state_o !== 4'd0 || RegW !== 1'b0 || MemW !== 1'b0) begin
        bad++; $display("FAIL rst_mul_after[%0d]: got state=%0d RegW=%0b MemW=%0b want 0 0 0", i, state_o, RegW, MemW);
      end
      @(negedge clk);
    end
    // Store interrupted while waiting in MEMWR.
    Op = 2'b01; Funct = 6'h00; MulOp = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = rd_s[i];
      #1;
      total++;
      if (state_o !== 4'(st_s[i])) begin
        bad++; $display("FAIL rst_str_seq[%0d]: got state=%0d want %0d", i, state_o, st_s[i]);
      end
      if (i < 4) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    total++;
    if (state_o !== 4'd0 || dut.wait_cnt_q !== '0 || MemW !== 1'b0) begin
      bad++; $display("FAIL rst_str_now: got state=%0d wait=%0d MemW=%0b want 0 0 0", state_o, dut.wait_cnt_q, MemW);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (state_o !== 4'd0 || RegW !== 1'b0 || MemW !== 1'b0) begin
        bad++; $display("FAIL rst_str_after[%0d]: got state=%0d RegW=%0b MemW=%0b want 0 0 0", i, state_o, RegW, MemW);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    // ADD reg, then branch, then ADD immediate, with no idle cycles between them.
    int st[12] = '{0, 1, 6, 8, 0, 1, 9, 0, 1, 7, 8, 0};
    logic [1:0] op[12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [5:0] fn[12] = '{6'h08, 6'h08, 6'h08, 6'h08, 6'h00, 6'h00, 6'h00, 6'h28, 6'h28, 6'h28, 6'h28, 6'h28};
    MulOp = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'b1;
      Op = op[i];
      Funct = fn[i];
      #1;
      total++;
      if ({state_o, ctl} !== {4'(st[i]), exp_ctl(st[i], 1'b1, 1'b0)}) begin
        bad++; $display("FAIL b2b[%0d]: got state=%0d ctl=%b want state=%0d ctl=%b", i, state_o, ctl, st[i], exp_ctl(st[i], 1'b1, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_ldr_wait();
    test_str_timeout();
    test_mul();
    test_mul_disabled();
    test_illegal_op();
    test_fetch_timeout_edge();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcycle_ctrl_fsm.md
Name: mcycle_ctrl_fsm

Overview:
- Main control FSM for the multi-cycle ARM datapath. Successor to the fixed 11-state controller.
- Adds a memory ready/wait handshake with a configurable timeout.
- Adds an optional iterative-multiply path with parametrised latency.
- Adds a sticky fault state for illegal opcodes and memory timeouts. Drives the same datapath control bundle as the existing controller, plus mem_req, mul_start, fault and a state debug port.

Parameters:
- MUL_EN, 1, 1 enables the MULEX/MULWB path; 0 sends MulOp instructions to the ordinary EXECUTER path.
- MUL_CYCLES, 4, number of cycles spent in MULEX (legal range 1..255).
- MEM_TIMEOUT, 16, maximum wait cycles per memory state before a fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Op  in  2  instruction op field
- Funct  in  6  instruction funct field; [5]=immediate, [0]=load/store L bit
- MulOp  in  1  decoder flag: data-processing instruction is a multiply
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active (FETCH, MEMRD, MEMWR)
- IRWrite  out  1  instruction register load enable
- AdrSrc  out  1  0 = PC address, 1 = ALU result address
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = reg B, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = multiplier result
- NextPC  out  1  PC update enable
- RegW  out  1  register file write enable
- MemW  out  1  memory write enable
- Branch  out  1  branch PC update
- ALUOp  out  1  1 = decode by Funct, 0 = add
- mul_start  out  1  single-cycle pulse that starts the multiplier
- fault  out  1  sticky fault flag
- state_o  out  4  current state encoding

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MULEX=10, MULWB=11, FAULT=12.
  - Codes 13-15 are unreachable and go to FAULT.
- Reset:
  - Asynchronous; state is FETCH, wait counter 0, multiply counter 0, fault 0.
  - All outputs take their FETCH values, with mem_ready gating as described below.
  - Reset mid-access or mid-multiply abandons the operation immediately; no partial RegW or MemW pulse follows.
- Transitions:
  - FETCH -> DECODE when mem_ready=1, else stay in FETCH.
  - DECODE, Op=00:
    - MulOp=1 and MUL_EN=1 and Funct[5]=0 -> MULEX.
    - Otherwise Funct[5]=1 -> EXECUTEI, Funct[5]=0 -> EXECUTER.
  - DECODE, Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FAULT.
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB when mem_ready=1, else stay.
  - MEMWR -> FETCH when mem_ready=1, else stay.
  - EXECUTER and EXECUTEI -> ALUWB.
  - MULEX stays for exactly MUL_CYCLES cycles, then -> MULWB.
  - MEMWB, ALUWB, MULWB, BRANCH -> FETCH.
  - FAULT stays in FAULT until reset.
- Outputs (Moore except the mem_ready gating; unlisted outputs are 0):
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0. IRWrite and NextPC equal mem_ready, so each asserts once per fetch.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0.
  - MEMRD: mem_req=1, AdrSrc=1.
  - MEMWR: mem_req=1, AdrSrc=1, MemW=1, with MemW held for every wait cycle.
  - MEMWB: RegW=1, ResultSrc=01.
  - ALUWB: RegW=1, ResultSrc=00.
  - MULEX: mul_start=1 in the first MULEX cycle only.
  - MULWB: RegW=1, ResultSrc=11.
  - BRANCH: Branch=1, ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0.
  - FAULT: all controls 0, fault=1.
- Wait counter:
  - Width $clog2(MEM_TIMEOUT+1). Clears on entry to any memory state and on mem_ready=1.
  - Increments on each cycle with mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT while mem_ready=0, next state is FAULT.
  - mem_ready=1 in that same cycle wins: the access completes normally.
- Multiply counter:
  - 8-bit; loads MUL_CYCLES-1 on DECODE->MULEX.
  - Decrements each MULEX cycle and exits at 0.
  - MUL_CYCLES=1 gives one MULEX cycle, with mul_start asserted in it.
- Throughput with zero wait states:
  - Data-processing 4 cycles; load 5; store 4; branch 3; multiply 3+MUL_CYCLES.

Test Plan:
- ADD reg (Op=00, Funct=0x08, MulOp=0), mem_ready tied 1 -> state sequence 0,1,6,8,0. RegW=1 only in the ALUWB cycle; IRWrite and NextPC each pulse once, in FETCH.
- LDR (Op=01, Funct[0]=1) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req=1 and AdrSrc=1, then MEMWB with RegW=1 and ResultSrc=01. Total 8 cycles.
- STR, MEM_TIMEOUT=4, mem_ready held 0 -> MemW=1 for 5 cycles, then state_o=12 and fault=1, sticky. Reset returns to FETCH with fault=0.
- MUL (Op=00, Funct[5]=0, MulOp=1), MUL_CYCLES=4 -> mul_start pulses 1 cycle, 4 MULEX cycles, then MULWB with RegW=1 and ResultSrc=11. Repeat with MUL_EN=0 -> takes the EXECUTER path.
- Op=11 in DECODE -> FAULT next cycle, all controls 0. Separately, an FETCH stall with mem_ready rising exactly at the timeout cycle -> goes to DECODE and no fault.
- Assert reset during MULEX cycle 2 and during a MEMWR wait -> FETCH immediately, counters 0, no RegW or MemW pulse after reset deasserts.
